reg_wb_arbiter: RTL and testbench

REG_WB_ARBITER -- requirements
Module: reg_wb_arbiter

---
 rtl/reg_wb_arbiter.sv | 100 ++++++++++
 tb/tb_reg_wb_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/reg_wb_arbiter.sv
// Writeback arbiter between the execute stage (A) and the load unit (B) in
// front of a single register-file write port. Requests are granted
// combinationally. The grant is round-robin when both requesters are valid.
// The accepted write is registered and presented one cycle later.
// Out-of-range destinations are still accepted, so the requester never
// deadlocks. They produce an addrErr pulse in place of a write strobe.

`ifndef REG_FILE_SIZE
`define REG_FILE_SIZE 16
`endif
`ifndef REG_FILE_ADDR_LEN
`define REG_FILE_ADDR_LEN 4
`endif

module reg_wb_arbiter #(
   parameter int NUM_REGS = 12,
   parameter int DATA_W   = `REG_FILE_SIZE,
   parameter int ADDR_W   = `REG_FILE_ADDR_LEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              stall,
   input  logic              aValid,
   input  logic [ADDR_W-1:0] aDest,
   input  logic [DATA_W-1:0] aData,
   output logic              aReady,
   input  logic              bValid,
   input  logic [ADDR_W-1:0] bDest,
   input  logic [DATA_W-1:0] bData,
   output logic              bReady,
   output logic              writeEn,
   output logic [ADDR_W-1:0] dest,
   output logic [DATA_W-1:0] writeVal,
   output logic              addrErr,
   output logic [7:0]        waitCnt
);

   logic              r_last_b;
   logic              r_write_en;
   logic              r_addr_err;
   logic [ADDR_W-1:0] r_dest;
   logic [DATA_W-1:0] r_write_val;
   logic [7:0]        r_wait_cnt;

   logic              w_open;
   logic              w_a_grant;
   logic              w_b_grant;
   logic              w_xfer;
   logic [ADDR_W-1:0] w_sel_dest;
   logic [DATA_W-1:0] w_sel_data;
   logic              w_in_range;
   logic              w_wait;

   // Grant selection: the port not granted most recently wins a contention
   always_comb begin
      w_open     = ~rst & ~stall;
      w_a_grant  = w_open & aValid & (~bValid | r_last_b);
      w_b_grant  = w_open & bValid & (~aValid | ~r_last_b);
      w_xfer     = w_a_grant | w_b_grant;
      w_sel_dest = w_b_grant ? bDest : aDest;
      w_sel_data = w_b_grant ? bData : aData;
      // Zero-extend before comparing so NUM_REGS == 2**ADDR_W does not wrap
      w_in_range = $unsigned(32'(w_sel_dest)) < $unsigned(32'(NUM_REGS));
      w_wait     = (aValid & ~w_a_grant) | (bValid & ~w_b_grant);
   end

   // Registered write port, error pulse, round-robin pointer and wait counter
   always_ff @(posedge clk) begin
      if (rst) begin
         r_last_b    <= 1'b1;
         r_write_en  <= 1'b0;
         r_addr_err  <= 1'b0;
         r_dest      <= '0;
         r_write_val <= '0;
         r_wait_cnt  <= 8'd0;
      end else begin
         r_write_en <= w_xfer & w_in_range;
         r_addr_err <= w_xfer & ~w_in_range;
         if (w_xfer) begin
            r_last_b <= w_b_grant;
         end
         if (w_xfer && w_in_range) begin
            r_dest      <= w_sel_dest;
            r_write_val <= w_sel_data;
         end
         if (w_wait && (r_wait_cnt != 8'hFF)) begin
            r_wait_cnt <= r_wait_cnt + 8'd1;
         end
      end
   end

   assign aReady   = w_a_grant;
   assign bReady   = w_b_grant;
   assign writeEn  = r_write_en;
   assign addrErr  = r_addr_err;
   assign dest     = r_dest;
   assign writeVal = r_write_val;
   assign waitCnt  = r_wait_cnt;

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// Bench for reg_wb_arbiter. It runs directed scenarios, then a randomized
// run against a behavioural model of the arbitration and writeback rules.
module tb_reg_wb_arbiter;

   localparam int NUM_REGS = 12;
   localparam int DATA_W   = 16;
   localparam int ADDR_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              stall;
   logic              aValid, bValid;
   logic [ADDR_W-1:0] aDest, bDest;
   logic [DATA_W-1:0] aData, bData;
   logic              aReady, bReady;
   logic              writeEn, addrErr;
   logic [ADDR_W-1:0] dest;
   logic [DATA_W-1:0] writeVal;
   logic [7:0]        waitCnt;

   int checks   = 0;
   int failures = 0;

   // Reference state: last winner plus the expected registered outputs
   bit                m_last_b = 1'b1;
   bit                m_we     = 1'b0;
   bit                m_err    = 1'b0;
   logic [ADDR_W-1:0] m_dest   = '0;
   logic [DATA_W-1:0] m_val    = '0;
   int                m_wait   = 0;

   always #5 clk = ~clk;

   reg_wb_arbiter #(
      .NUM_REGS(NUM_REGS),
      .DATA_W  (DATA_W),
      .ADDR_W  (ADDR_W)
   ) dut (
      .clk     (clk),
      .rst     (rst),
      .stall   (stall),
      .aValid  (aValid),
      .aDest   (aDest),
      .aData   (aData),
      .aReady  (aReady),
      .bValid  (bValid),
      .bDest   (bDest),
      .bData   (bData),
      .bReady  (bReady),
      .writeEn (writeEn),
      .dest    (dest),
      .writeVal(writeVal),
      .addrErr (addrErr),
      .waitCnt (waitCnt)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One clock: predict grants, check the readies mid-cycle, then advance
   // the model across the edge and check the registered outputs.
   task automatic step(output bit ga, output bit gb);
      bit                waiting;
      logic [ADDR_W-1:0] d;
      logic [DATA_W-1:0] v;
      ga = 1'b0;
      gb = 1'b0;
      if (!rst && !stall) begin
         if (aValid && bValid) begin
            if (m_last_b) ga = 1'b1;
            else          gb = 1'b1;
         end else if (aValid) ga = 1'b1;
         else if (bValid)     gb = 1'b1;
      end
      @(negedge clk);
      check("aReady", 32'(aReady), 32'(ga));
      check("bReady", 32'(bReady), 32'(gb));
      @(posedge clk);
      #1;
      if (rst) begin
         m_we = 0; m_err = 0; m_dest = '0; m_val = '0; m_wait = 0; m_last_b = 1;
      end else begin
         waiting = (aValid && !ga) || (bValid && !gb);
         if (waiting && m_wait < 255) m_wait++;
         m_we  = 0;
         m_err = 0;
         if (ga || gb) begin
            d = ga ? aDest : bDest;
            v = ga ? aData : bData;
            m_last_b = gb;
            if (int'(d) < NUM_REGS) begin
               m_we = 1; m_dest = d; m_val = v;
            end else begin
               m_err = 1;
            end
         end
      end
      check("writeEn",  32'(writeEn),  32'(m_we));
      check("addrErr",  32'(addrErr),  32'(m_err));
      check("dest",     32'(dest),     32'(m_dest));
      check("writeVal", 32'(writeVal), 32'(m_val));
      check("waitCnt",  32'(waitCnt),  32'(m_wait));
   endtask

   task automatic do_reset();
      bit ga, gb;
      rst = 1;
      step(ga, gb);
      rst = 0;
   endtask

   initial begin
      bit ga, gb;
      rst = 1; stall = 0;
      aValid = 0; aDest = '0; aData = '0;
      bValid = 0; bDest = '0; bData = '0;
      step(ga, gb);
      step(ga, gb);
      check("rst_we",   32'(writeEn),  32'd0);
      check("rst_wait", 32'(waitCnt),  32'd0);
      check("rst_val",  32'(writeVal), 32'd0);
      rst = 0;

      // Single A write, one-cycle latency, strobe lasts one cycle
      aValid = 1; aDest = 4'd3; aData = 16'h00AB;
      step(ga, gb);
      check("t1_grant", 32'(ga), 32'd1);
      check("t1_we",    32'(writeEn), 32'd1);
      check("t1_dest",  32'(dest), 32'd3);
      check("t1_val",   32'(writeVal), 32'h00AB);
      aValid = 0;
      step(ga, gb);
      check("t1_we_off", 32'(writeEn), 32'd0);

      // Contention after reset: A first, then B, no bubble
      do_reset();
      aValid = 1; aDest = 4'd1; aData = 16'h11;
      bValid = 1; bDest = 4'd2; bData = 16'h22;
      step(ga, gb);
      check("rr_first_a", 32'(ga), 32'd1);
      check("rr_dest1",   32'(dest), 32'd1);
      aValid = 0;
      step(ga, gb);
      check("rr_then_b",  32'(gb), 32'd1);
      check("rr_we2",     32'(writeEn), 32'd1);
      check("rr_dest2",   32'(dest), 32'd2);
      check("rr_wait",    32'(waitCnt), 32'd1);
      bValid = 0;
      step(ga, gb);

      // Out-of-range destination: accepted, error pulse, outputs hold
      bValid = 1; bDest = 4'd12; bData = 16'h55;
      step(ga, gb);
      check("oor_grant", 32'(gb), 32'd1);
      check("oor_we",    32'(writeEn), 32'd0);
      check("oor_err",   32'(addrErr), 32'd1);
      check("oor_dest",  32'(dest), 32'd2);
      check("oor_val",   32'(writeVal), 32'h22);
      bValid = 0;
      step(ga, gb);
      check("oor_err_off", 32'(addrErr), 32'd0);

      // Long stall: no grants, counter saturates, grant on release
      stall = 1; aValid = 1; aDest = 4'd4; aData = 16'h1234;
      for (int i = 0; i < 300; i++) step(ga, gb);
      check("stall_sat", 32'(waitCnt), 32'd255);
      stall = 0;
      step(ga, gb);
      check("stall_rel_grant", 32'(ga), 32'd1);
      check("stall_rel_dest",  32'(dest), 32'd4);
      aValid = 0;
      step(ga, gb);

      // Same destination from both ports: B lands last
      do_reset();
      aValid = 1; aDest = 4'd5; aData = 16'h1;
      bValid = 1; bDest = 4'd5; bData = 16'h2;
      step(ga, gb);
      check("same_val1", 32'(writeVal), 32'h1);
      aValid = 0;
      step(ga, gb);
      check("same_we2",  32'(writeEn), 32'd1);
      check("same_dest", 32'(dest), 32'd5);
      check("same_val2", 32'(writeVal), 32'h2);
      bValid = 0;
      step(ga, gb);

      // Transfer then reset: write lost, pointer back to A-first
      aValid = 1; aDest = 4'd7; aData = 16'h77;
      step(ga, gb);
      step(ga, gb);
      aValid = 1; aDest = 4'd8; aData = 16'h88;
      bValid = 1; bDest = 4'd9; bData = 16'h99;
      step(ga, gb);
      check("pre_rst_b", 32'(gb), 32'd1);
      aValid = 0; bValid = 0;
      rst = 1;
      step(ga, gb);
      check("lost_we",   32'(writeEn), 32'd0);
      check("lost_wait", 32'(waitCnt), 32'd0);
      rst = 0;
      aValid = 1; aDest = 4'd1; aData = 16'hA1;
      bValid = 1; bDest = 4'd2; bData = 16'hB2;
      step(ga, gb);
      check("post_rst_a", 32'(ga), 32'd1);
      aValid = 0;
      step(ga, gb);
      bValid = 0;

      // Randomized traffic with protocol-correct requesters
      for (int i = 0; i < 2000; i++) begin
         if (!aValid && $urandom_range(0, 2) == 0) begin
            aValid = 1;
            aDest  = ADDR_W'($urandom_range(0, 15));
            aData  = DATA_W'($urandom);
         end
         if (!bValid && $urandom_range(0, 2) == 0) begin
            bValid = 1;
            bDest  = ADDR_W'($urandom_range(0, 15));
            bData  = DATA_W'($urandom);
         end
         stall = ($urandom_range(0, 4) == 0);
         rst   = ($urandom_range(0, 59) == 0);
         step(ga, gb);
         if (ga) aValid = 0;
         if (gb) bValid = 0;
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
